// File: rtl/mmio_arbiter.sv
// Round-robin arbiter and sequencer for two masters sharing the MMIO slave bus.
// One transaction at a time; decode misses and hung slaves end with an error response.
module mmio_arbiter #(
    parameter logic [15:0] TIMEOUT  = 16'd255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        sys_clk,
    input  logic        rst,

    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_work,
    input  logic        bus_done,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        last_grant_nxt;
    logic        gnt;
    logic        gnt_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [31:0] resp_rdata;
    logic [31:0] resp_rdata_nxt;
    logic        resp_err;
    logic        resp_err_nxt;
    logic        bus_read_nxt;
    logic        bus_write_nxt;
    logic [31:0] bus_addr_nxt;
    logic [31:0] bus_wdata_nxt;
    logic        req0;
    logic        req1;
    logic        sel1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    // master 1 wins only when alone, or on a tie when master 0 was served last
    assign sel1 = req1 & (~req0 | ~last_grant);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            last_grant <= last_grant_nxt;
            gnt        <= gnt_nxt;
            cnt        <= cnt_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
            bus_read   <= bus_read_nxt;
            bus_write  <= bus_write_nxt;
            bus_addr   <= bus_addr_nxt;
            bus_wdata  <= bus_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gnt_nxt        = gnt;
        cnt_nxt        = cnt;
        resp_rdata_nxt = resp_rdata;
        resp_err_nxt   = resp_err;
        bus_read_nxt   = bus_read;
        bus_write_nxt  = bus_write;
        bus_addr_nxt   = bus_addr;
        bus_wdata_nxt  = bus_wdata;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_nxt        = sel1;
                    last_grant_nxt = sel1;
                    bus_addr_nxt   = sel1 ? m1_addr : m0_addr;
                    bus_wdata_nxt  = sel1 ? m1_wdata : m0_wdata;
                    // a request with both read and write high is issued as a read
                    bus_read_nxt   = sel1 ? m1_read : m0_read;
                    bus_write_nxt  = sel1 ? (m1_write & ~m1_read) : (m0_write & ~m0_read);
                    cnt_nxt        = '0;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
                if (bus_done) begin
                    resp_rdata_nxt = bus_read ? bus_rdata : '0;
                    resp_err_nxt   = 1'b0;
                    bus_read_nxt   = 1'b0;
                    bus_write_nxt  = 1'b0;
                    state_nxt      = RESP;
                end else if (((cnt == '0) && !bus_work) || (cnt == TIMEOUT)) begin
                    resp_rdata_nxt = bus_read ? ERR_DATA : '0;
                    resp_err_nxt   = 1'b1;
                    bus_read_nxt   = 1'b0;
                    bus_write_nxt  = 1'b0;
                    state_nxt      = RESP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m0_done  = (state == RESP) & ~gnt;
    assign m1_done  = (state == RESP) & gnt;
    assign m0_rdata = m0_done ? resp_rdata : '0;
    assign m1_rdata = m1_done ? resp_rdata : '0;
    assign m0_err   = m0_done & resp_err;
    assign m1_err   = m1_done & resp_err;

endmodule
